alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue/register-manager side of the ALU interface. Holds the 32-entry architectural register file and accepts one decoded instruction at a time.
- Drives the ALU operand/opcode ports (unit, sub_unit, sel, rs1, rs2, rd) and waits for the ALU's ok.
- Captures result/branch, then either writes rd back or reports a branch redirect.
- Sits between the decoder and the ALU.

Parameters:
- xlen, 32, datapath width (register and operand width).
- WDOG_CYCLES, 16, ALU wait limit in cycles; used only when ALU_WATCHDOG_EN is defined.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- instr_valid_i  input  1  decoded instruction valid
- instr_ready_o  output  1  block can accept an instruction
- unit_i  input  2  ALU unit field
- sub_unit_i  input  3  sub-unit field (1 = branch)
- sel_i  input  4  operation select
- rs1_addr_i  input  5  source register 1 index
- rs2_addr_i  input  5  source register 2 index
- rd_addr_i  input  5  destination register index
- imm_i  input  xlen  immediate value
- use_imm_i  input  1  1: ALU rs2 operand = imm_i instead of regfile[rs2]
- unit_o / sub_unit_o / sel_o  output  2/3/4  to ALU
- rs1_o / rs2_o  output  xlen  operands to ALU
- rd_o  output  5  destination index to ALU
- ok_i  input  1  ALU accepted/completed
- result_i  input  xlen  ALU result
- branch_i  input  1  ALU branch decision
- retire_o  output  1  one-cycle pulse per completed instruction
- wb_we_o  output  1  regfile write strobe (observability)
- wb_addr_o  output  5  written register index
- wb_data_o  output  xlen  written data
- branch_o  output  1  one-cycle pulse, branch taken
- branch_target_o  output  xlen  captured result_i when branch_o is high
- err_o  output  1  one-cycle pulse on ALU watchdog abort

Behaviour:
- Async reset (rst=1):
  - State = IDLE; all 32 registers = 0.
  - All outputs 0, except instr_ready_o = 1 after reset is released.
  - Any in-flight instruction is dropped with no write and no pulse.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready_o = 1.
  - On instr_valid_i, latch fields and read operands: rs1 = regfile[rs1_addr_i]; rs2 = use_imm_i ? imm_i : regfile[rs2_addr_i]. Then go to EXEC.
  - Index 0 always reads 0.
- EXEC:
  - instr_ready_o = 0.
  - ALU ports are driven from the latched registers and stay stable for the whole state.
  - If ok_i = 1, capture result_i and branch_i, then go to WB. Otherwise remain in EXEC.
- WB (exactly 1 cycle), then go to IDLE. retire_o = 1.
  - Branch (sub_unit = 1): no regfile write. branch_o = captured branch; branch_target_o = captured result.
  - Otherwise: write regfile[rd] = result if rd != 0, with wb_we_o = 1, wb_addr_o = rd, wb_data_o = result.
  - rd = 0: wb_we_o = 0; retire_o is still 1.
- Latency: accept at cycle N, ALU ports valid at N+1, WB at N+2 (ok_i high at N+1). Best-case throughput is 1 instruction per 3 cycles.
- The WB write is visible to an instruction accepted in the following IDLE cycle, so there is no RAW hazard by construction.
- wb_addr_o / wb_data_o / branch_target_o hold their last values between pulses.
- ALU port outputs hold their last values in IDLE.
- instr_valid_i outside IDLE is ignored; the decoder must hold it until the ready handshake.

Optional Feature:
- Macro: ALU_WATCHDOG_EN.
- Defined:
  - A counter clears on EXEC entry and increments each EXEC cycle with ok_i = 0.
  - When it reaches WDOG_CYCLES, err_o pulses for 1 cycle and the FSM returns to IDLE.
  - On abort: no write, no retire_o, no branch_o.
  - ok_i arriving in the same cycle as the limit wins; the instruction completes normally.
- Undefined: EXEC waits indefinitely; err_o is tied 0; no counter logic is present.

Test Plan:
- Reset, then issue unit=0, sub_unit=2, sel=0, use_imm=1, imm=5, rd=3. ALU model gives ok at N+1, result=5 -> wb_we_o=1, wb_addr_o=3, wb_data_o=5, retire_o at N+2. A following read of x3 returns 5.
- Write to rd=0 with result=0xDEADBEEF -> wb_we_o=0, retire_o=1. Next instruction with rs1=0 drives rs1_o=0.
- Branch: sub_unit=1, branch_i=1, result_i=0x100 -> branch_o=1, branch_target_o=0x100, no write. Same with branch_i=0 -> branch_o=0, retire_o=1.
- ALU holds ok_i low for 4 cycles -> ALU ports stay stable, instr_ready_o=0 throughout. WB occurs on the cycle after ok_i; instr_valid_i during the wait is ignored.
- Assert rst during EXEC -> no retire/write. All registers read 0 afterwards; instr_ready_o=1.
- With ALU_WATCHDOG_EN and WDOG_CYCLES=16, unit=1 and ok_i never high -> err_o pulse 16 cycles after EXEC entry, return to IDLE, no write. Repeat with ok_i exactly at the limit -> normal retire, no err_o.

Source files
------------

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue
// Brief   : ALU issue stage with 32-entry register file; optional ALU
//           watchdog enabled by ALU_WATCHDOG_EN.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int XLEN = 32
`ifdef ALU_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [1:0]      unit_i,
  input  logic [2:0]      sub_unit_i,
  input  logic [3:0]      sel_i,
  input  logic [4:0]      rs1_addr_i,
  input  logic [4:0]      rs2_addr_i,
  input  logic [4:0]      rd_addr_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            use_imm_i,
  output logic [1:0]      unit_o,
  output logic [2:0]      sub_unit_o,
  output logic [3:0]      sel_o,
  output logic [XLEN-1:0] rs1_o,
  output logic [XLEN-1:0] rs2_o,
  output logic [4:0]      rd_o,
  input  logic            ok_i,
  input  logic [XLEN-1:0] result_i,
  input  logic            branch_i,
  output logic            retire_o,
  output logic            wb_we_o,
  output logic [4:0]      wb_addr_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            branch_o,
  output logic [XLEN-1:0] branch_target_o,
  output logic            err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [2:0] c_sub_branch = 3'd1;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_regs [32];
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_abort;

  logic [1:0]      r_unit;
  logic [2:0]      r_sub_unit;
  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [4:0]      r_rd;
  logic            r_retire;
  logic            r_wb_we;
  logic [4:0]      r_wb_addr;
  logic [XLEN-1:0] r_wb_data;
  logic            r_branch;
  logic [XLEN-1:0] r_branch_target;

  assign w_rs1_val = (rs1_addr_i == 5'd0) ? '0 : r_regs[rs1_addr_i];
  assign w_rs2_val = use_imm_i ? imm_i :
                     ((rs2_addr_i == 5'd0) ? '0 : r_regs[rs2_addr_i]);

`ifdef ALU_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] r_wdog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (r_state == S_IDLE) begin
      r_wdog <= '0;
    end else if (r_state == S_EXEC && !ok_i && r_wdog != WDOG_W'(WDOG_CYCLES)) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end

  // A late ok_i in the limit cycle takes priority over the abort.
  assign w_abort = (r_state == S_EXEC) && !ok_i && (r_wdog == WDOG_W'(WDOG_CYCLES));
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid_i) w_next = S_EXEC;
      S_EXEC: begin
        if (ok_i)         w_next = S_WB;
        else if (w_abort) w_next = S_IDLE;
      end
      S_WB:    w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_unit          <= '0;
      r_sub_unit      <= '0;
      r_sel           <= '0;
      r_rs1           <= '0;
      r_rs2           <= '0;
      r_rd            <= '0;
      r_retire        <= 1'b0;
      r_wb_we         <= 1'b0;
      r_wb_addr       <= '0;
      r_wb_data       <= '0;
      r_branch        <= 1'b0;
      r_branch_target <= '0;
    end else begin
      r_retire <= 1'b0;
      r_wb_we  <= 1'b0;
      r_branch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid_i) begin
            r_unit     <= unit_i;
            r_sub_unit <= sub_unit_i;
            r_sel      <= sel_i;
            r_rs1      <= w_rs1_val;
            r_rs2      <= w_rs2_val;
            r_rd       <= rd_addr_i;
          end
        end
        S_EXEC: begin
          // Writeback outputs are staged here so they appear during WB.
          if (ok_i) begin
            r_retire <= 1'b1;
            if (r_sub_unit == c_sub_branch) begin
              r_branch <= branch_i;
              if (branch_i) r_branch_target <= result_i;
            end else if (r_rd != 5'd0) begin
              r_wb_we   <= 1'b1;
              r_wb_addr <= r_rd;
              r_wb_data <= result_i;
            end
          end
        end
        S_WB: begin
          if (r_wb_we) r_regs[r_wb_addr] <= r_wb_data;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready_o   = (r_state == S_IDLE) && !rst;
  assign unit_o          = r_unit;
  assign sub_unit_o      = r_sub_unit;
  assign sel_o           = r_sel;
  assign rs1_o           = r_rs1;
  assign rs2_o           = r_rs2;
  assign rd_o            = r_rd;
  assign retire_o        = r_retire;
  assign wb_we_o         = r_wb_we;
  assign wb_addr_o       = r_wb_addr;
  assign wb_data_o       = r_wb_data;
  assign branch_o        = r_branch;
  assign branch_target_o = r_branch_target;
  assign err_o           = w_abort;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue
// Brief   : Self-checking bench for alu_issue: directed table, reset and
//           randomized sequences against a register-file reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid_i = 1'b0;
  logic        instr_ready_o;
  logic [1:0]  unit_i = '0;
  logic [2:0]  sub_unit_i = '0;
  logic [3:0]  sel_i = '0;
  logic [4:0]  rs1_addr_i = '0, rs2_addr_i = '0, rd_addr_i = '0;
  logic [31:0] imm_i = '0;
  logic        use_imm_i = 1'b0;
  logic [1:0]  unit_o;
  logic [2:0]  sub_unit_o;
  logic [3:0]  sel_o;
  logic [31:0] rs1_o, rs2_o;
  logic [4:0]  rd_o;
  logic        ok_i = 1'b0;
  logic [31:0] result_i = '0;
  logic        branch_i = 1'b0;
  logic        retire_o, wb_we_o, branch_o, err_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o, branch_target_o;

  alu_issue dut (
    .clk(clk), .rst(rst),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .unit_i(unit_i), .sub_unit_i(sub_unit_i), .sel_i(sel_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .imm_i(imm_i), .use_imm_i(use_imm_i),
    .unit_o(unit_o), .sub_unit_o(sub_unit_o), .sel_o(sel_o),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .ok_i(ok_i), .result_i(result_i), .branch_i(branch_i),
    .retire_o(retire_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_data_o(wb_data_o), .branch_o(branch_o),
    .branch_target_o(branch_target_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  unit;
    logic [2:0]  sub;
    logic [3:0]  sel;
    logic [4:0]  rs1a, rs2a, rda;
    logic [31:0] imm;
    logic        use_imm;
    int          wait_n;
    logic [31:0] result;
    logic        br;
    logic [31:0] e_rs1, e_rs2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_br;
    logic [31:0] e_tgt;
  } vec_t;

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] ref_regs [32];
  logic [4:0]  g_addr;
  logic [31:0] g_data, g_tgt;
  vec_t        tbl [7];
  vec_t        v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one instruction and walk it through EXEC and WB, checking each cycle.
  task automatic run(input vec_t t);
    @(negedge clk);
    chk("retire_low_idle", {31'd0, retire_o}, 32'd0);
    chk("ready_idle", {31'd0, instr_ready_o}, 32'd1);
    unit_i = t.unit; sub_unit_i = t.sub; sel_i = t.sel;
    rs1_addr_i = t.rs1a; rs2_addr_i = t.rs2a; rd_addr_i = t.rda;
    imm_i = t.imm; use_imm_i = t.use_imm; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    chk("unit_o", {30'd0, unit_o}, {30'd0, t.unit});
    chk("sub_unit_o", {29'd0, sub_unit_o}, {29'd0, t.sub});
    chk("sel_o", {28'd0, sel_o}, {28'd0, t.sel});
    chk("rs1_o", rs1_o, t.e_rs1);
    chk("rs2_o", rs2_o, t.e_rs2);
    chk("rd_o", {27'd0, rd_o}, {27'd0, t.rda});
    chk("ready_exec", {31'd0, instr_ready_o}, 32'd0);
    for (int w = 0; w < t.wait_n; w++) begin
      instr_valid_i = 1'b1;
      rs1_addr_i = 5'($urandom); rs2_addr_i = 5'($urandom); rd_addr_i = 5'($urandom);
      imm_i = $urandom; use_imm_i = 1'($urandom); sub_unit_i = 3'($urandom);
      @(negedge clk);
      chk("wait_rs1_stable", rs1_o, t.e_rs1);
      chk("wait_rs2_stable", rs2_o, t.e_rs2);
      chk("wait_rd_stable", {27'd0, rd_o}, {27'd0, t.rda});
      chk("wait_sub_stable", {29'd0, sub_unit_o}, {29'd0, t.sub});
      chk("wait_ready_low", {31'd0, instr_ready_o}, 32'd0);
      chk("wait_no_retire", {31'd0, retire_o}, 32'd0);
    end
    instr_valid_i = 1'b0;
    ok_i = 1'b1; result_i = t.result; branch_i = t.br;
    @(negedge clk);
    ok_i = 1'b0; result_i = $urandom; branch_i = 1'($urandom);
    chk("retire_wb", {31'd0, retire_o}, 32'd1);
    chk("wb_we", {31'd0, wb_we_o}, {31'd0, t.e_we});
    chk("wb_addr", {27'd0, wb_addr_o}, {27'd0, t.e_addr});
    chk("wb_data", wb_data_o, t.e_data);
    chk("branch_o", {31'd0, branch_o}, {31'd0, t.e_br});
    chk("branch_target", branch_target_o, t.e_tgt);
    chk("err_wb", {31'd0, err_o}, 32'd0);
  endtask

  // Reference: architectural register file plus held writeback/branch values.
  task automatic model_commit(input vec_t t);
    if (t.sub != 3'd1 && t.rda != 5'd0) begin
      ref_regs[t.rda] = t.result;
      g_addr = t.rda;
      g_data = t.result;
    end
    if (t.sub == 3'd1 && t.br) g_tgt = t.result;
  endtask

  function automatic logic [31:0] rd_ref(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : ref_regs[a];
  endfunction

  task automatic model_fill(inout vec_t t);
    t.e_rs1 = rd_ref(t.rs1a);
    t.e_rs2 = t.use_imm ? t.imm : rd_ref(t.rs2a);
    t.e_we  = (t.sub != 3'd1) && (t.rda != 5'd0);
    t.e_br  = (t.sub == 3'd1) ? t.br : 1'b0;
    t.e_addr = t.e_we ? t.rda : g_addr;
    t.e_data = t.e_we ? t.result : g_data;
    t.e_tgt  = (t.sub == 3'd1 && t.br) ? t.result : g_tgt;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    g_addr = '0; g_data = '0; g_tgt = '0;

    //          unit sub sel rs1 rs2 rd  imm  use wait result  br e_rs1 e_rs2 we addr data br tgt
    tbl[0] = '{2'd0, 3'd2, 4'd0, 5'd0, 5'd0, 5'd3, 32'd5, 1'b1, 0, 32'd5, 1'b0,
               32'd0, 32'd5, 1'b1, 5'd3, 32'd5, 1'b0, 32'd0};
    tbl[1] = '{2'd0, 3'd0, 4'd1, 5'd3, 5'd0, 5'd4, 32'd9, 1'b0, 0, 32'd7, 1'b0,
               32'd5, 32'd0, 1'b1, 5'd4, 32'd7, 1'b0, 32'd0};
    tbl[2] = '{2'd0, 3'd0, 4'd2, 5'd4, 5'd3, 5'd0, 32'd0, 1'b0, 0, 32'hDEADBEEF, 1'b0,
               32'd7, 32'd5, 1'b0, 5'd4, 32'd7, 1'b0, 32'd0};
    tbl[3] = '{2'd2, 3'd3, 4'd3, 5'd0, 5'd4, 5'd5, 32'd1, 1'b0, 0, 32'h55, 1'b0,
               32'd0, 32'd7, 1'b1, 5'd5, 32'h55, 1'b0, 32'd0};
    tbl[4] = '{2'd1, 3'd1, 4'd4, 5'd3, 5'd5, 5'd6, 32'd0, 1'b0, 0, 32'h100, 1'b1,
               32'd5, 32'h55, 1'b0, 5'd5, 32'h55, 1'b1, 32'h100};
    tbl[5] = '{2'd1, 3'd1, 4'd5, 5'd4, 5'd3, 5'd6, 32'd0, 1'b0, 0, 32'h200, 1'b0,
               32'd7, 32'd5, 1'b0, 5'd5, 32'h55, 1'b0, 32'h100};
    tbl[6] = '{2'd3, 3'd0, 4'd15, 5'd3, 5'd5, 5'd6, 32'd0, 1'b0, 4, 32'h1234, 1'b0,
               32'd5, 32'h55, 1'b1, 5'd6, 32'h1234, 1'b0, 32'h100};

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready_o}, 32'd0);
    chk("rst_retire", {31'd0, retire_o}, 32'd0);
    chk("rst_rs1_o", rs1_o, 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    rst = 1'b0;
    #1 chk("ready_after_rst", {31'd0, instr_ready_o}, 32'd1);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i]);
      model_commit(tbl[i]);
    end

    // Reset while an instruction sits in EXEC.
    @(negedge clk);
    unit_i = 2'd0; sub_unit_i = 3'd0; rs1_addr_i = 5'd3; rd_addr_i = 5'd7;
    use_imm_i = 1'b0; instr_valid_i = 1'b1;
    @(negedge clk);
    instr_valid_i = 1'b0;
    chk("exec_before_rst", {31'd0, instr_ready_o}, 32'd0);
    ok_i = 1'b1; result_i = 32'hCAFE0000; rst = 1'b1;
    #1;
    chk("rst_exec_retire", {31'd0, retire_o}, 32'd0);
    chk("rst_exec_we", {31'd0, wb_we_o}, 32'd0);
    @(negedge clk);
    chk("rst_hold_retire", {31'd0, retire_o}, 32'd0);
    rst = 1'b0; ok_i = 1'b0;
    #1 chk("ready_after_rst2", {31'd0, instr_ready_o}, 32'd1);
    chk("wb_addr_after_rst", {27'd0, wb_addr_o}, 32'd0);
    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    g_addr = '0; g_data = '0; g_tgt = '0;
    for (int i = 1; i < 32; i += 2) begin
      v = '{default: '0};
      v.rs1a = 5'(i); v.rs2a = 5'((i + 1) % 32); v.rda = 5'd0; v.result = $urandom;
      model_fill(v);
      run(v);
      model_commit(v);
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      v = '{default: '0};
      v.unit = 2'($urandom); v.sel = 4'($urandom);
      v.sub = ($urandom_range(0, 2) == 0) ? 3'd1 : 3'($urandom);
      v.rs1a = 5'($urandom); v.rs2a = 5'($urandom);
      v.rda = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      v.imm = $urandom; v.use_imm = 1'($urandom);
      v.wait_n = $urandom_range(0, 3);
      v.result = $urandom; v.br = 1'($urandom);
      model_fill(v);
      run(v);
      model_commit(v);
    end

`ifdef ALU_WATCHDOG_EN
    begin
      int cnt;
      @(negedge clk);
      unit_i = 2'd1; sub_unit_i = 3'd0; rd_addr_i = 5'd9; instr_valid_i = 1'b1;
      @(negedge clk);
      instr_valid_i = 1'b0;
      cnt = 0;
      while (!err_o && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk("wdog_delay", cnt, 32'd16);
      chk("wdog_no_retire", {31'd0, retire_o}, 32'd0);
      @(negedge clk);
      chk("wdog_err_pulse", {31'd0, err_o}, 32'd0);
      chk("wdog_idle", {31'd0, instr_ready_o}, 32'd1);
      chk("wdog_no_we", {31'd0, wb_we_o}, 32'd0);
      instr_valid_i = 1'b1;
      @(negedge clk);
      instr_valid_i = 1'b0;
      repeat (16) @(negedge clk);
      ok_i = 1'b1; result_i = 32'h0BADF00D;
      #1 chk("wdog_ok_wins_err", {31'd0, err_o}, 32'd0);
      @(negedge clk);
      ok_i = 1'b0;
      chk("wdog_ok_retire", {31'd0, retire_o}, 32'd1);
      chk("wdog_ok_data", wb_data_o, 32'h0BADF00D);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
